// File: rtl/fp_add_sub_unit.sv
// Two-stage saturating fixed-point adder/subtractor: S1 holds operands,
// S2 holds clamped a+b / a-b with overflow flags, plus a clamp-event counter.
`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

module fp_sat_lane #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic [WIDTH:0] ax, bx, ex;

  // One guard bit makes the exact result representable; a guard/sign mismatch is overflow.
  always_comb begin
    ax  = {a[WIDTH-1], a};
    bx  = {b[WIDTH-1], b};
    ex  = sub ? (ax - bx) : (ax + bx);
    ovf = ex[WIDTH] ^ ex[WIDTH-1];
    if (!ovf)          y = ex[WIDTH-1:0];
    else if (ex[WIDTH]) y = {1'b1, {(WIDTH-1){1'b0}}};
    else               y = {1'b0, {(WIDTH-1){1'b1}}};
  end
endmodule

module fp_add_sub_unit #(
  parameter int WIDTH   = `FP_WIDTH,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic [WIDTH-1:0]   diff,
  output logic               sum_ovf,
  output logic               diff_ovf,
  input  logic               clear_count,
  output logic [COUNT_W-1:0] ovf_count
);
  logic                   v1, v2, adv1, adv2;
  logic [WIDTH-1:0]       a1, b1;
  logic [1:0][WIDTH-1:0]  res;
  logic [1:0]             res_ovf;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Lane 0 adds, lane 1 subtracts.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    fp_sat_lane #(.WIDTH(WIDTH)) u_lane (
      .a(a1), .b(b1), .sub(g == 1), .y(res[g]), .ovf(res_ovf[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= a;
        b1 <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2       <= 1'b0;
      sum      <= '0;
      diff     <= '0;
      sum_ovf  <= 1'b0;
      diff_ovf <= 1'b0;
    end else if (adv2) begin
      v2       <= v1;
      sum      <= res[0];
      diff     <= res[1];
      sum_ovf  <= res_ovf[0];
      diff_ovf <= res_ovf[1];
    end
  end

  // Counts delivered results only; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_count <= '0;
    else if (clear_count)
      ovf_count <= '0;
    else if (v2 && out_ready && (sum_ovf || diff_ovf) && !(&ovf_count))
      ovf_count <= ovf_count + 1'b1;
  end
endmodule

// File: tb/tb_fp_add_sub_unit.sv
// Scoreboard bench for fp_add_sub_unit: expected results queued on input
// handshake, popped and compared on output handshake.
module tb_fp_add_sub_unit;
  typedef struct packed {
    logic [15:0] s;
    logic [15:0] d;
    logic        so;
    logic        dv;
  } res_t;

  logic        clk = 0, reset_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [15:0] a_i = 0, b_i = 0, sum, diff;
  logic        sum_ovf, diff_ovf, clear_count = 0;
  logic [15:0] ovf_count;

  int   total = 0, bad = 0, n_out = 0;
  res_t sb[$];
  logic [15:0] model_cnt = 0;
  logic        hold = 0;
  res_t        held;

  fp_add_sub_unit #(.WIDTH(16), .COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .diff(diff), .sum_ovf(sum_ovf), .diff_ovf(diff_ovf),
    .clear_count(clear_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    int xi, yi, s, d;
    res_t r;
    xi = $signed(x); yi = $signed(y);
    s = xi + yi; d = xi - yi;
    r.so = (s > 32767) || (s < -32768);
    r.dv = (d > 32767) || (d < -32768);
    r.s = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : s[15:0];
    r.d = (d > 32767) ? 16'h7FFF : (d < -32768) ? 16'h8000 : d[15:0];
    return r;
  endfunction

  // Monitor: inputs are stable at negedge, so handshakes seen here happen at the next posedge.
  always @(negedge clk) begin
    res_t obs, e;
    logic exp_rdy;
    obs = {sum, diff, sum_ovf, diff_ovf};
    exp_rdy = !(sb.size() == 2 && !out_ready);
    total++;
    if (in_ready !== exp_rdy) begin
      bad++; $display("FAIL in_ready: got %b want %b (inflight=%0d)", in_ready, exp_rdy, sb.size());
    end
    total++;
    if (ovf_count !== model_cnt) begin
      bad++; $display("FAIL ovf_count: got %h want %h", ovf_count, model_cnt);
    end
    if (hold && out_valid) begin
      total++;
      if (obs !== held) begin
        bad++; $display("FAIL stall_stable: got %h want %h", obs, held);
      end
    end
    hold = reset_n && out_valid && !out_ready;
    held = obs;
    if (!reset_n) begin
      model_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL unexpected_output: got %h want none", obs);
        end else begin
          e = sb.pop_front();
          n_out++;
          if (obs !== e) begin
            bad++; $display("FAIL result: got %h want %h", obs, e);
          end
          if (!clear_count && (e.so || e.dv) && model_cnt != 16'hFFFF) model_cnt = model_cnt + 1;
        end
      end
      if (clear_count) model_cnt = 0;
      if (in_valid && in_ready) sb.push_back(model(a_i, b_i));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    in_valid = 1; a_i = x; b_i = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++; $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) begin
      total++; bad++; $display("FAIL wait_out_timeout: out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, ovf_count, sum, diff} !== {1'b0, 1'b1, 16'h0, 16'h0, 16'h0}) begin
      bad++; $display("FAIL reset_state: ov=%b ir=%b cnt=%h sum=%h diff=%h want 0 1 0 0 0",
                      out_valid, in_ready, ovf_count, sum, diff);
    end
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1;
    send(16'h0500, 16'h0200);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    total++;
    if ({out_valid, sum, diff, sum_ovf, diff_ovf, ovf_count} !== {1'b1, 16'h0700, 16'h0300, 2'b00, 16'h0}) begin
      bad++; $display("FAIL basic: ov=%b sum=%h diff=%h flags=%b%b cnt=%h want 1 0700 0300 00 0",
                      out_valid, sum, diff, sum_ovf, diff_ovf, ovf_count);
    end
    step();
  endtask

  task automatic test_overflow();
    send(16'h4000, 16'h4000);
    wait_out();
    total++;
    if ({sum, sum_ovf, diff, diff_ovf} !== {16'h7FFF, 1'b1, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL pos_clamp: sum=%h so=%b diff=%h do=%b want 7fff 1 0000 0", sum, sum_ovf, diff, diff_ovf);
    end
    step();
    @(negedge clk);
    total++;
    if (ovf_count !== 16'd1) begin bad++; $display("FAIL count_one: got %h want 0001", ovf_count); end
    step();
    send(16'h8000, 16'h0001);
    wait_out();
    total++;
    if ({sum, sum_ovf, diff, diff_ovf} !== {16'h8001, 1'b0, 16'h8000, 1'b1}) begin
      bad++; $display("FAIL neg_diff_clamp: sum=%h so=%b diff=%h do=%b want 8001 0 8000 1", sum, sum_ovf, diff, diff_ovf);
    end
    step();
    send(16'h8000, 16'h8000);
    wait_out();
    total++;
    if ({sum, sum_ovf, diff, diff_ovf} !== {16'h8000, 1'b1, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL neg_sum_clamp: sum=%h so=%b diff=%h do=%b want 8000 1 0000 0", sum, sum_ovf, diff, diff_ovf);
    end
    step();
    @(negedge clk);
    total++;
    if (ovf_count !== 16'd3) begin bad++; $display("FAIL count_three: got %h want 0003", ovf_count); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [8] = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000, 16'hC000, 16'h0F0F};
    logic [15:0] tb [8] = '{16'h0002, 16'h0001, 16'h7FFF, 16'hEDCC, 16'h8000, 16'hC000, 16'h4001, 16'h00F0};
    int sent = 0, base = n_out;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid  = (sent < 8);
      a_i = ta[sent % 8]; b_i = tb[sent % 8];
      @(negedge clk);
      if (cyc == 3) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full: in_ready=%b want 0", in_ready); end
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 0;
    total++;
    if (n_out - base !== 8 || sent !== 8) begin
      bad++; $display("FAIL stream_count: delivered=%0d sent=%0d want 8 8", n_out - base, sent);
    end
  endtask

  task automatic test_counter_sat();
    out_ready = 1;
    clear_count = 1; step(); clear_count = 0;
    in_valid = 1; a_i = 16'h4000; b_i = 16'h4000;
    repeat (65535) step();
    in_valid = 0;
    repeat (4) step();
    @(negedge clk);
    total++;
    if (ovf_count !== 16'hFFFF) begin bad++; $display("FAIL count_fill: got %h want ffff", ovf_count); end
    step();
    send(16'h4000, 16'h4000);
    wait_out(); step();
    @(negedge clk);
    total++;
    if (ovf_count !== 16'hFFFF) begin bad++; $display("FAIL count_saturate: got %h want ffff", ovf_count); end
    step();
    out_ready = 0;
    send(16'h8000, 16'h7FFF);
    wait_out();
    step();
    out_ready = 1; clear_count = 1;
    step();
    clear_count = 0;
    @(negedge clk);
    total++;
    if ({ovf_count, out_valid} !== {16'h0, 1'b0}) begin
      bad++; $display("FAIL clear_wins: cnt=%h ov=%b want 0000 0", ovf_count, out_valid);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    send(16'h1111, 16'h0001);
    send(16'h2222, 16'h0002);
    reset_n = 0;
    sb.delete();
    model_cnt = 0;
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_mid: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    step();
    reset_n = 1; out_ready = 1;
    send(16'h0123, 16'h0011);
    wait_out();
    total++;
    if ({sum, diff} !== {16'h0134, 16'h0112}) begin
      bad++; $display("FAIL post_reset_first: sum=%h diff=%h want 0134 0112", sum, diff);
    end
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL no_ghost: out_valid=%b want 0", out_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_counter_sat();
    test_reset_midstream();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL drain: pending=%0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_sub_unit.md
# fp_add_sub_unit

Pipelined, saturating signed fixed-point adder/subtractor for the skin-tone datapath. It produces `a+b` and `a-b` together for each accepted operand pair. Operands arrive on a valid/ready stream in the shared `fp_width` fixed-point format from `datapath.vh`. Results leave on a second valid/ready stream after two pipeline stages, with per-result overflow flags and a running saturation-event counter. This is the hardware end of the fixed-point add/sub path that software models with real-to-fixed conversion.

## Interface
- `WIDTH`, default `` `fp_width ``: operand/result width, two's complement. The binary point position is irrelevant to add/sub.
- `COUNT_W`, default 16: width of the saturation-event counter.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  unit can accept operands this cycle
- `a`  in  WIDTH  signed operand A
- `b`  in  WIDTH  signed operand B
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `sum`  out  WIDTH  saturated `a+b`
- `diff`  out  WIDTH  saturated `a-b`
- `sum_ovf`  out  1  `sum` was clamped
- `diff_ovf`  out  1  `diff` was clamped
- `clear_count`  in  1  synchronous clear of `ovf_count`
- `ovf_count`  out  COUNT_W  number of delivered results with any clamp

## Operation
- Stage 1 (S1) registers `a` and `b`, valid bit `v1`. Stage 2 (S2) registers `sum`, `diff` and both flags, valid bit `v2`.
- Advance rules:
  - `adv2 = !v2 || out_ready`
  - `adv1 = !v1 || adv2`
  - `in_ready = adv1`. This is a combinational path from `out_ready`; it is intentional.
- Input handshake (`in_valid && in_ready`): S1 loads operands and `v1` is set.
- When `adv1` is true and there is no input handshake, `v1` clears.
- When `adv2` is true, S2 loads the computed results from S1 and `v2 <= v1`.
- When a stage does not advance, its registers hold; data and flags stay stable while `out_valid && !out_ready`.
- Arithmetic is computed combinationally from the S1 registers:
  - Sign-extend both operands to WIDTH+1 bits; form `s = a+b` and `d = a-b` exactly.
  - Overflow when bit WIDTH of the exact result differs from bit WIDTH-1.
  - On overflow, clamp to `0111…1` if the exact result is positive, else to `1000…0`, and set the matching flag.
  - With no overflow, the result is the low WIDTH bits and the flag is 0.
- Counter:
  - On an output handshake (`out_valid && out_ready`) with `sum_ovf || diff_ovf`, `ovf_count` increments by exactly 1, even when both flags are set.
  - The counter saturates at all-ones and does not wrap.
  - `clear_count` zeroes the counter on the next edge. Clear wins over a simultaneous increment.
- `out_valid = v2`.
- Reset (any time, including mid-stream):
  - `v1`, `v2`, S1 data, S2 data, both flags and `ovf_count` go to 0 immediately.
  - `out_valid` = 0.
  - `in_ready` = 1, since it is combinational from the cleared valids.
  - In-flight pairs are discarded, not delivered.

## Timing
- Latency: an operand pair accepted at edge N appears on `out_valid` after edge N+1, so it is available for handshake in cycle N+1 (2 registers).
- Throughput: one pair per cycle while `out_ready` is held high.
- Backpressure: with `out_ready` low, the unit absorbs at most 2 pairs; `in_ready` then drops in the same cycle both stages are full.
- When stalled and full, raising `out_ready` raises `in_ready` in the same cycle (no bubble).
- Ordering is strictly FIFO. No pair is dropped or duplicated under any `in_valid`/`out_ready` pattern.

## Test plan
Directed scenarios use WIDTH=16.
- Reset, then a=16'h0500, b=16'h0200 with `out_ready`=1 → two cycles later: sum=16'h0700, diff=16'h0300, both flags 0, `ovf_count`=0.
- a=16'h4000, b=16'h4000 → sum=16'h7FFF, sum_ovf=1, diff=16'h0000, diff_ovf=0, `ovf_count`=1 after the handshake.
- a=16'h8000, b=16'h0001 → sum=16'h8001, diff=16'h8000, diff_ovf=1. Next: a=16'h8000, b=16'h8000 → sum=16'h8000, sum_ovf=1, diff=0.
- Streaming with back-pressure:
  - Stimulus: 8 consecutive pairs, `out_ready` low for cycles 2–5.
  - Required: `in_ready` low exactly while S1 and S2 are full, outputs held stable, all 8 results delivered in order and matching a reference model.
- Counter boundaries:
  - Preload via 65535 clamping results: `ovf_count`=16'hFFFF, and stays there on a further clamp.
  - `clear_count` asserted in the same cycle as a clamping handshake → 0.
- Reset mid-stream with 2 pairs in flight:
  - Required: `out_valid` drops immediately and `in_ready`=1.
  - After release, the next pair is the first output; the discarded pairs never appear.
